// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access frame controller.
// Frame: write = cmd, data, crc, x; read = cmd, crc, x, x (four bytes per select window).
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_DATA = 3'd1,
        W_CRC  = 3'd2,
        R_CRC  = 3'd3,
        R_WAIT = 3'd4,
        R_STAT = 3'd5,
        TAIL   = 3'd6
    } frame_state_e;

    localparam logic [7:0] FILL         = 8'h00;
    localparam logic [7:0] STAT_OK      = 8'hA5;
    localparam logic [7:0] STAT_ERR     = 8'h5A;
    localparam logic [7:0] CRC_POLY     = 8'h07;
    localparam logic [7:0] RD_CRC_FAIL  = 8'hFF;
    localparam int         CMD_WRITE_BIT = 7;

    // Byte counter saturates here; anything past byte 3 is ignored.
    localparam logic [2:0] BYTE_CNT_MAX = 3'd4;

endpackage

// File: rtl/crc8_byte_step.sv
// One-byte CRC-8 update: MSB first, no reflection, no final XOR.
// Purely combinational so the frame controller can fold each rx byte in the same clk.
module crc8_byte_step (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    input  logic [7:0] poly,
    output logic [7:0] crc_out
);

    logic [7:0] w_acc;

    always_comb begin
        w_acc = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (w_acc[7]) begin
                w_acc = {w_acc[6:0], 1'b0} ^ poly;
            end else begin
                w_acc = {w_acc[6:0], 1'b0};
            end
        end
        crc_out = w_acc;
    end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame decoder behind spi_slave: collects cmd/data/crc bytes, checks CRC-8,
// issues single-cycle register reads/writes and schedules the MISO bytes.
module spi_frame_ctrl
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       spi_ss,
    input  logic       rx,
    input  logic [7:0] rx_data,
    input  logic       tx,
    output logic [7:0] tx_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_ok,
    output logic       crc_err,
    output logic [2:0] o_dbg_state
);

    // Strobes: rx is a one-clk pulse meaning rx_data holds a complete byte; tx is a
    // one-clk pulse meaning spi_slave has just copied tx_data into its shifter.
    // Neither has back-pressure, and nothing is sampled while ena is low.

    frame_state_e r_state;
    frame_state_e w_state_nxt;
    logic [2:0]   r_cnt;
    logic [7:0]   r_crc;

    logic         w_rx_ok;
    logic         w_crc_match;
    logic [7:0]   w_crc_seed;
    logic [7:0]   w_crc_step;

    logic [2:0]   w_cnt_nxt;
    logic [7:0]   w_crc_nxt;
    logic [7:0]   w_tx_nxt;
    logic [6:0]   w_addr_nxt;
    logic [7:0]   w_wdata_nxt;
    logic         w_we_nxt;
    logic         w_re_nxt;
    logic         w_ok_nxt;
    logic         w_err_nxt;

    assign w_rx_ok     = rx && (r_cnt != BYTE_CNT_MAX);
    assign w_crc_match = (rx_data == r_crc);
    assign w_crc_seed  = (r_state == IDLE) ? 8'h00 : r_crc;
    assign o_dbg_state = r_state;

    crc8_byte_step u_crc (
        .crc_in  (w_crc_seed),
        .data    (rx_data),
        .poly    (CRC_POLY),
        .crc_out (w_crc_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rx_ok) begin
                    w_state_nxt = rx_data[CMD_WRITE_BIT] ? W_DATA : R_CRC;
                end
            end
            W_DATA: begin
                if (w_rx_ok) w_state_nxt = W_CRC;
            end
            W_CRC: begin
                if (w_rx_ok) w_state_nxt = TAIL;
            end
            R_CRC: begin
                if (w_rx_ok) w_state_nxt = w_crc_match ? R_WAIT : R_STAT;
            end
            // Sit here through the reg_re clk; read data arrives the clk after.
            R_WAIT: begin
                if (!reg_re) w_state_nxt = R_STAT;
            end
            R_STAT: begin
                if (w_rx_ok) w_state_nxt = TAIL;
            end
            TAIL:    w_state_nxt = TAIL;
            default: w_state_nxt = IDLE;
        endcase
        if (spi_ss) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_cnt_nxt   = w_rx_ok ? (r_cnt + 3'd1) : r_cnt;
        w_crc_nxt   = r_crc;
        w_tx_nxt    = tx ? FILL : tx_data;
        w_addr_nxt  = reg_addr;
        w_wdata_nxt = reg_wdata;
        w_we_nxt    = 1'b0;
        w_re_nxt    = 1'b0;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = crc_err;

        // Scheduled loads below override the FILL revert from a coincident tx.
        case (r_state)
            IDLE: begin
                if (w_rx_ok) begin
                    w_addr_nxt = rx_data[6:0];
                    w_err_nxt  = 1'b0;
                    w_crc_nxt  = w_crc_step;
                end
            end
            W_DATA: begin
                if (w_rx_ok) begin
                    w_wdata_nxt = rx_data;
                    w_crc_nxt   = w_crc_step;
                end
            end
            W_CRC: begin
                if (w_rx_ok) begin
                    if (w_crc_match) begin
                        w_we_nxt = 1'b1;
                        w_ok_nxt = 1'b1;
                        w_tx_nxt = STAT_OK;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_tx_nxt  = STAT_ERR;
                    end
                end
            end
            R_CRC: begin
                if (w_rx_ok) begin
                    if (w_crc_match) begin
                        w_re_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_tx_nxt  = RD_CRC_FAIL;
                    end
                end
            end
            R_WAIT: begin
                if (!reg_re) w_tx_nxt = reg_rdata;
            end
            R_STAT: begin
                if (w_rx_ok) begin
                    w_tx_nxt = crc_err ? STAT_ERR : STAT_OK;
                    w_ok_nxt = !crc_err;
                end
            end
            default: begin
            end
        endcase

        // Deselect clears the frame but keeps the last address, data and error flag.
        if (spi_ss) begin
            w_cnt_nxt = 3'd0;
            w_crc_nxt = 8'h00;
            w_tx_nxt  = FILL;
            w_we_nxt  = 1'b0;
            w_re_nxt  = 1'b0;
            w_ok_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 3'd0;
            r_crc     <= 8'h00;
            tx_data   <= FILL;
            reg_addr  <= 7'd0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_ok  <= 1'b0;
            crc_err   <= 1'b0;
        end else if (ena) begin
            r_cnt     <= w_cnt_nxt;
            r_crc     <= w_crc_nxt;
            tx_data   <= w_tx_nxt;
            reg_addr  <= w_addr_nxt;
            reg_wdata <= w_wdata_nxt;
            reg_we    <= w_we_nxt;
            reg_re    <= w_re_nxt;
            frame_ok  <= w_ok_nxt;
            crc_err   <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: table of whole frames plus hand sequences
// for deselect abort, async reset mid-read and clock-enable hold.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       spi_ss = 1'b1;
  logic       rx = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx = 1'b0;
  logic [7:0] tx_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_ok;
  logic       crc_err;
  logic [2:0] dbg_state;

  spi_frame_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .spi_ss(spi_ss),
    .rx(rx), .rx_data(rx_data), .tx(tx), .tx_data(tx_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .frame_ok(frame_ok), .crc_err(crc_err), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // register model: read data valid exactly one clk after reg_re, junk otherwise
  logic [7:0] rd_val = 8'h00;
  logic       re_d;
  always @(posedge clk or negedge rst) begin
    if (!rst) re_d <= 1'b0;
    else      re_d <= reg_re;
  end
  assign reg_rdata = re_d ? rd_val : 8'hEE;

  int checks = 0;
  int errors = 0;
  int n_we, n_re, n_ok;
  logic overlap = 1'b0;

  always @(negedge clk) begin
    if (reg_we) n_we++;
    if (reg_re) n_re++;
    if (frame_ok) n_ok++;
    if (reg_we && reg_re) overlap = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    return x;
  endfunction

  typedef struct {
    logic [7:0] mosi[6];
    int         nb;
    logic [7:0] rd;
    logic [7:0] miso[6];
    int         n_we, n_re, n_ok;
    logic       err;
    logic [6:0] addr;
    logic [7:0] wdata;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] cur_mosi[6];
  logic [7:0] cur_miso[6];
  logic       we_lat;
  logic [7:0] rd_lat;

  task automatic set_vec(input int i, input logic [7:0] b0, b1, b2, b3, b4, b5,
                         input int nb, input logic [7:0] rd,
                         input logic [7:0] m0, m1, m2, m3, m4, m5,
                         input int nwe, nre, nok, input logic err,
                         input logic [6:0] addr, input logic [7:0] wdata);
    vecs[i].mosi[0] = b0; vecs[i].mosi[1] = b1; vecs[i].mosi[2] = b2;
    vecs[i].mosi[3] = b3; vecs[i].mosi[4] = b4; vecs[i].mosi[5] = b5;
    vecs[i].miso[0] = m0; vecs[i].miso[1] = m1; vecs[i].miso[2] = m2;
    vecs[i].miso[3] = m3; vecs[i].miso[4] = m4; vecs[i].miso[5] = m5;
    vecs[i].nb = nb; vecs[i].rd = rd;
    vecs[i].n_we = nwe; vecs[i].n_re = nre; vecs[i].n_ok = nok;
    vecs[i].err = err; vecs[i].addr = addr; vecs[i].wdata = wdata;
  endtask

  // one SPI byte: tx strobe (MISO byte captured), then rx strobe with the MOSI byte
  task automatic send_byte(input int i);
    tx = 1'b1;
    cur_miso[i] = tx_data;
    @(negedge clk);
    tx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    rx_data = cur_mosi[i];
    @(negedge clk);
    rx = 1'b0;
    if (i == 2) we_lat = reg_we;
    repeat (2) @(negedge clk);
    if (i == 1) rd_lat = tx_data;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int nb);
    n_we = 0; n_re = 0; n_ok = 0;
    spi_ss = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < nb; i++) send_byte(i);
    spi_ss = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // clock/reset block with reset-value checks
    repeat (3) @(negedge clk);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_reg_addr", reg_addr, 7'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_strobes", {reg_we, reg_re, frame_ok, crc_err}, 4'b0000);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    //       mosi                                          nb rd     miso                                       we re ok err addr   wdata
    set_vec(0, 8'h85, 8'h3C, 8'h43, 8'h00, 8'h00, 8'h00, 4, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 1, 0, 1, 0, 7'h05, 8'h3C);
    set_vec(1, 8'h12, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'h77, 8'h00, 8'h00, 8'h77, 8'hA5, 8'h00, 8'h00, 0, 1, 1, 0, 7'h12, 8'h3C);
    set_vec(2, 8'h85, 8'h3C, 8'h44, 8'h00, 8'h00, 8'h00, 4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 1, 7'h05, 8'h3C);
    set_vec(3, 8'h81, 8'h55, crc_step(crc_step(8'h00, 8'h81), 8'h55), 8'h00, 8'h00, 8'h00,
            4, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 1, 0, 1, 0, 7'h01, 8'h55);
    set_vec(4, 8'h12, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'h77, 8'h00, 8'h00, 8'hFF, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 1, 7'h12, 8'h55);
    set_vec(5, 8'h85, 8'h3C, 8'h43, 8'hC7, 8'h11, 8'h22, 6, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 1, 0, 1, 0, 7'h05, 8'h3C);
    set_vec(6, 8'h7F, crc_step(8'h00, 8'h7F), 8'h00, 8'h00, 8'h00, 8'h00,
            4, 8'hC3, 8'h00, 8'h00, 8'hC3, 8'hA5, 8'h00, 8'h00, 0, 1, 1, 0, 7'h7F, 8'h3C);

    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < 6; j++) cur_mosi[j] = vecs[v].mosi[j];
      rd_val = vecs[v].rd;
      run_frame(vecs[v].nb);
      for (int j = 0; j < vecs[v].nb; j++) check($sformatf("v%0d_miso%0d", v, j), cur_miso[j], vecs[v].miso[j]);
      check($sformatf("v%0d_we_cnt", v), n_we, vecs[v].n_we);
      check($sformatf("v%0d_re_cnt", v), n_re, vecs[v].n_re);
      check($sformatf("v%0d_ok_cnt", v), n_ok, vecs[v].n_ok);
      check($sformatf("v%0d_crc_err", v), crc_err, vecs[v].err);
      check($sformatf("v%0d_addr", v), reg_addr, vecs[v].addr);
      check($sformatf("v%0d_wdata", v), reg_wdata, vecs[v].wdata);
      check($sformatf("v%0d_we_lat", v), we_lat, vecs[v].n_we);
      check($sformatf("v%0d_rd_lat", v), rd_lat, vecs[v].miso[2]);
      check($sformatf("v%0d_idle", v), dbg_state, 3'd0);
    end

    // deselect after the write data byte: no write, next frame decodes cleanly
    n_we = 0;
    cur_mosi[0] = 8'h85; cur_mosi[1] = 8'h3C;
    spi_ss = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(0);
    send_byte(1);
    spi_ss = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_we", n_we, 0);
    check("abort_tx_fill", tx_data, 8'h00);
    check("abort_state", dbg_state, 3'd0);
    cur_mosi[0] = 8'h83; cur_mosi[1] = 8'h99;
    cur_mosi[2] = crc_step(crc_step(8'h00, 8'h83), 8'h99); cur_mosi[3] = 8'h00;
    run_frame(4);
    check("post_abort_we", n_we, 1);
    check("post_abort_addr", reg_addr, 7'h03);
    check("post_abort_wdata", reg_wdata, 8'h99);
    check("post_abort_stat", cur_miso[3], 8'hA5);

    // bad read crc then deselect: scheduled 0xFF is dropped, crc_err holds
    cur_mosi[0] = 8'h12; cur_mosi[1] = 8'h00;
    spi_ss = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(0);
    send_byte(1);
    check("badrd_tx_ff", tx_data, 8'hFF);
    spi_ss = 1'b1;
    repeat (2) @(negedge clk);
    check("badrd_abort_fill", tx_data, 8'h00);
    check("badrd_abort_err_hold", crc_err, 1'b1);

    // clock enable low: rx is ignored entirely
    ena = 1'b0;
    spi_ss = 1'b0;
    rx = 1'b1; rx_data = 8'hC4;
    @(negedge clk);
    rx = 1'b0;
    spi_ss = 1'b1;
    @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    check("ena_hold_addr", reg_addr, 7'h12);
    check("ena_hold_err", crc_err, 1'b1);

    // async reset in the clk where reg_re is high
    rd_val = 8'h77;
    cur_mosi[0] = 8'h12;
    spi_ss = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(0);
    rx = 1'b1; rx_data = 8'h7E;
    @(negedge clk);
    rx = 1'b0;
    check("pre_rst_re", reg_re, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_re", reg_re, 1'b0);
    check("arst_addr", reg_addr, 7'h00);
    check("arst_wdata", reg_wdata, 8'h00);
    check("arst_misc", {reg_we, frame_ok, crc_err, tx_data}, 11'h000);
    check("arst_state", dbg_state, 3'd0);
    spi_ss = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cur_mosi[0] = 8'h12; cur_mosi[1] = 8'h7E; cur_mosi[2] = 8'h00; cur_mosi[3] = 8'h00;
    run_frame(4);
    check("post_rst_rdata", cur_miso[2], 8'h77);
    check("post_rst_stat", cur_miso[3], 8'hA5);
    check("post_rst_re", n_re, 1);

    check("we_re_exclusive", overlap, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
